frv_dmem_responder: RTL and testbench
=====================================

# frv_dmem_responder

Data-memory responder: the target end of the core's `dmem_*` request/response interface. It grants load/store requests into a word-addressed on-chip SRAM and returns one in-order response per granted request through a small response FIFO. Byte-strobe writes are supported, and out-of-range accesses are flagged. It sits between the core's LSU port and local data RAM, and is also used as the standard memory model in core-level benches.

## Interface
Parameters:
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words. Valid byte range is `0 .. 4*MEM_WORDS-1`.
- `RSP_DEPTH`, 2: response FIFO entries (>=1). This sets the maximum number of un-acked requests.

Ports (all synchronous to `g_clk`):
- `g_clk` in 1: global clock.
- `g_reset` in 1: reset. Synchronous and active-high.
- `gnt_hold` in 1: when high, forces `dmem_gnt` low (throttling and test hook).
- `dmem_req` in 1: request valid.
- `dmem_wen` in 1: 1 = store, 0 = load.
- `dmem_strb` in 4: byte write strobes. Ignored for loads.
- `dmem_wdata` in 32: store data.
- `dmem_addr` in 32: byte address. Bits [1:0] are ignored (word access).
- `dmem_gnt` out 1: request accepted this cycle.
- `dmem_recv` out 1: response valid.
- `dmem_ack` in 1: response consumed.
- `dmem_error` out 1: response carries a bus error.
- `dmem_rdata` out 32: load data. 0 for stores and errors.

## Operation
- Accept event is `dmem_req && dmem_gnt`.
- `dmem_gnt` is combinational and equals `dmem_req && !gnt_hold && !g_reset && (occ < RSP_DEPTH)`.
  - `occ = fifo_count + pend - pop`.
  - `pend` is the 1-bit SRAM read stage.
  - `pop = dmem_recv && dmem_ack`.
- On accept, index `widx = dmem_addr[31:2]` and `oor = (widx >= MEM_WORDS)`.
  - Store, in range: write byte lanes i where `dmem_strb[i]` is set, in the same cycle.
  - Load, in range: SRAM read issued.
  - Out of range: no SRAM write.
- Cycle after accept (pend stage): push `{error=oor, rdata = (load && !oor) ? sram_q : 0}` into the FIFO.
- `dmem_recv = fifo_count != 0`. `dmem_rdata` and `dmem_error` show the FIFO head and are forced to 0 when the FIFO is empty.
- Pop on `dmem_recv && dmem_ack`. Push and pop in the same cycle are allowed in any state; the count is unchanged.
- Responses are strictly in grant order, with exactly one response per grant.
- `dmem_ack` without `dmem_recv` is ignored.
- Read-after-write to the same word on back-to-back accepts returns the new data, because the SRAM write occurs in the accept cycle and the read in the next.
- FIFO overflow cannot occur by construction of `occ`. A push when full is an assertion failure.
- Inputs are required stable while `dmem_req && !dmem_gnt`. This is checked by assertion and not relied on by the RTL.

## Timing
- Reset values: `dmem_recv=0`, `dmem_error=0`, `dmem_rdata=0`; `fifo_count=0`, `pend=0`.
  - `dmem_gnt` is 0 while `g_reset` is high.
  - SRAM contents are NOT reset.
- Latency: accept in cycle N gives `dmem_recv` high in cycle N+1, at the earliest.
- Throughput: one accept per cycle sustained while `dmem_ack` is held high, for any `RSP_DEPTH` >= 1.
- Back-pressure: with `dmem_ack` low, at most `RSP_DEPTH` accepts, then `dmem_gnt` stays low until a pop. The pop cycle itself may grant.
- Reset mid-operation: the cycle after `g_reset` is sampled high, the pending stage and FIFO are empty and `dmem_recv=0`.
  - Responses in flight are discarded.
  - A store accepted in the same cycle as reset is not written (`dmem_gnt=0`).
- `gnt_hold` takes effect combinationally in the same cycle.
- Responses already queued are unaffected by `gnt_hold`.

## Structure
- `frv_common.svh`: shared constants.
  - Response entry width `RSP_W = 33` (error + rdata).
  - Field positions `RSP_ERR = 32` and `RSP_DATA = 31:0`.
- Sub-module `frv_dmem_rsp_fifo`: a synchronous FIFO of `RSP_DEPTH` x `RSP_W` with `push`, `pop`, `count`, `head`.
  - Reset is `g_reset`.
  - Simultaneous push and pop are allowed when full or empty.
- The SRAM is an inferred byte-lane array inside the top module. There are no vendor macros.
- Expected size: about 200 lines in total.

## Test plan
- Write then read.
  - Stimulus: store `0xDEADBEEF`, strb `0xF`, addr `0x10`; then load `0x10`.
  - Required: 2 grants; second `dmem_recv` arrives one cycle after its grant with `dmem_rdata=0xDEADBEEF`, `dmem_error=0`; the store response has `rdata=0`.
- Partial store.
  - Stimulus: store `0x0000AB00`, strb `0x2`, addr `0x10`; then load.
  - Required: read returns `0xDEADABEF`.
- Out of range, `MEM_WORDS=1024`.
  - Stimulus: store `0xFFFFFFFF` at `0x1000`; then load `0x1000`; then load `0x0`.
  - Required: first two responses have `dmem_error=1`, `rdata=0`; word 0 is unchanged.
- Back-pressure, `RSP_DEPTH=2`.
  - Stimulus: 4 back-to-back load requests, `dmem_ack=0` for 5 cycles, then held at 1.
  - Required: only 2 grants while ack is low; the remaining 2 are granted one per pop; 4 responses arrive in order with the correct data.
- Throttle and reset.
  - Stimulus: `gnt_hold=1` with `dmem_req=1` for 3 cycles, then release.
  - Required: `dmem_gnt=0` during hold.
  - Stimulus: with 2 queued responses, assert `g_reset` for 1 cycle.
  - Required: next cycle `dmem_recv=0`, `dmem_rdata=0`; a subsequent load returns pre-reset memory contents.
- Streaming.
  - Stimulus: 16 alternating store/load requests to the same word, `dmem_ack=1` constantly.
  - Required: 16 grants in 16 consecutive cycles; each load returns the immediately preceding store's data.

Source files
------------

// File: rtl/frv_dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// frv_dmem_responder_pkg
// Shared constants and the response entry type for the data-memory responder.
//   RSP_W      : width of one response FIFO entry (error flag + read data)
//   RSP_ERR    : bit position of the error flag inside an entry
//   RSP_DATA_W : width of the read-data field, occupying bits [RSP_DATA_W-1:0]
//   dmem_rsp_t : packed view of an entry; its layout matches the constants
// -----------------------------------------------------------------------------
package frv_dmem_responder_pkg;

  localparam int RSP_W      = 33;
  localparam int RSP_ERR    = 32;
  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic                  error;
    logic [RSP_DATA_W-1:0] rdata;
  } dmem_rsp_t;

  // Builds a response; read data is only ever meaningful for good loads.
  function automatic dmem_rsp_t make_rsp(input logic err, input logic is_load,
                                         input logic [RSP_DATA_W-1:0] data);
    dmem_rsp_t r;
    r.error = err;
    r.rdata = (is_load && !err) ? data : '0;
    return r;
  endfunction

endpackage

// File: rtl/frv_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// frv_dmem_responder_if
// The core's dmem request/response bus.
//   master : core LSU side   (drives req/wen/strb/wdata/addr/ack)
//   slave  : memory side     (drives gnt/recv/error/rdata)
// -----------------------------------------------------------------------------
interface frv_dmem_responder_if;

  logic        dmem_req;
  logic        dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_recv;
  logic        dmem_ack;
  logic        dmem_error;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr, dmem_ack,
    input  dmem_gnt, dmem_recv, dmem_error, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr, dmem_ack,
    output dmem_gnt, dmem_recv, dmem_error, dmem_rdata
  );

endinterface

// File: rtl/frv_dmem_rsp_fifo.sv
// -----------------------------------------------------------------------------
// frv_dmem_rsp_fifo
// Synchronous ring-buffer FIFO holding in-order dmem responses.
//   g_clk, g_reset : clock and synchronous active-high reset
//   push, push_data: write one entry (accepted when not full, or when full
//                    together with a pop)
//   pop            : drop the head entry (ignored when empty)
//   count          : number of stored entries, 0..DEPTH
//   head           : oldest entry; undefined contents while count == 0
// -----------------------------------------------------------------------------
module frv_dmem_rsp_fifo
  import frv_dmem_responder_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int W     = RSP_W,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order or block scheduling.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are deliberately left out of reset; validity is
  // tracked by count/pointers, and a reset port would block RAM inference.
  always_ff @(posedge g_clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  assign head = store[rd_ptr];

  // The responder's occupancy accounting never pushes into a full FIFO
  // without a simultaneous pop.
  assert property (@(posedge g_clk) disable iff (g_reset)
                   !(push && full && !pop));

endmodule

// File: rtl/frv_dmem_responder.sv
// -----------------------------------------------------------------------------
// frv_dmem_responder
// Target end of the core's dmem bus: grants load/store requests into a
// word-addressed byte-lane SRAM and returns one in-order response per grant.
//   g_clk    : clock
//   g_reset  : synchronous active-high reset (flushes in-flight responses,
//              leaves SRAM contents alone)
//   gnt_hold : forces dmem_gnt low while high
//   dmem     : slave side of the dmem bus
// Pipeline: accept cycle (SRAM write / read issue) -> pend stage (SRAM data
// valid, entry formed) -> response FIFO. While the FIFO is empty the pend
// entry is presented directly, so a response is visible the cycle after its
// grant and one grant per cycle is sustainable even with a 1-entry FIFO.
// -----------------------------------------------------------------------------
module frv_dmem_responder
  import frv_dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int RSP_DEPTH = 2
) (
  input logic                  g_clk,
  input logic                  g_reset,
  input logic                  gnt_hold,
  frv_dmem_responder_if.slave  dmem
);

  localparam int          AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          CW      = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

  logic [29:0]     widx;
  logic            oor;
  logic            accept;
  logic            pop;
  logic [CW:0]     occ;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [RSP_W-1:0] fifo_head;

  logic [3:0][7:0] sram [MEM_WORDS];
  logic [31:0]     sram_q;

  logic            pend;
  logic            pend_err;
  logic            pend_load;
  dmem_rsp_t       pend_rsp;
  dmem_rsp_t       out_rsp;
  logic            recv;
  logic            unused_addr_lsbs;

  // ---------------------------------------------------------------------------
  // Grant: occupancy counts everything already owed a response, minus the
  // entry leaving this cycle, so the pop cycle itself can grant.
  // ---------------------------------------------------------------------------
  assign widx   = dmem.dmem_addr[31:2];
  assign oor    = ({2'b00, widx} >= 32'(MEM_WORDS));
  assign occ    = {1'b0, fifo_count} + (CW + 1)'(pend) - (CW + 1)'(pop);
  assign accept = dmem.dmem_req && dmem.dmem_gnt;

  assign dmem.dmem_gnt = dmem.dmem_req && !gnt_hold && !g_reset && (occ < DEPTH_C);

  // Byte offset bits carry no meaning for word accesses.
  assign unused_addr_lsbs = &{1'b0, dmem.dmem_addr[1:0]};

  // ---------------------------------------------------------------------------
  // SRAM: write in the accept cycle, registered read data in the next, which
  // gives read-after-write forwarding for free on back-to-back accepts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge g_clk) begin
    if (accept && !oor) begin
      if (dmem.dmem_wen) begin
        for (int i = 0; i < 4; i++) begin
          if (dmem.dmem_strb[i]) sram[widx[AW-1:0]][i] <= dmem.dmem_wdata[8*i +: 8];
        end
      end else begin
        sram_q <= sram[widx[AW-1:0]];
      end
    end
  end

  // Pend stage: one entry in flight between the SRAM read and the FIFO.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      pend      <= 1'b0;
      pend_err  <= 1'b0;
      pend_load <= 1'b0;
    end else begin
      pend      <= accept;
      pend_err  <= oor;
      pend_load <= !dmem.dmem_wen;
    end
  end

  assign pend_rsp = make_rsp(pend_err, pend_load, sram_q);

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  assign fifo_empty = (fifo_count == '0);
  assign recv       = !fifo_empty || pend;
  assign pop        = recv && dmem.dmem_ack;
  assign fifo_pop   = pop && !fifo_empty;
  // A pend entry consumed straight from the bypass never enters the FIFO.
  assign fifo_push  = pend && !(fifo_empty && pop);

  frv_dmem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (RSP_W)
  ) u_rsp_fifo (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .push      (fifo_push),
    .push_data (pend_rsp),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // NOTE: the default assignment first guarantees every path drives out_rsp,
  // so no latch is inferred for the idle (nothing to return) case.
  always_comb begin
    out_rsp = '0;
    if (!fifo_empty) out_rsp = dmem_rsp_t'(fifo_head);
    else if (pend)   out_rsp = pend_rsp;
  end

  assign dmem.dmem_recv  = recv;
  assign dmem.dmem_error = out_rsp.error;
  assign dmem.dmem_rdata = out_rsp.rdata;

  // A stalled request must hold its payload until granted.
  assert property (@(posedge g_clk) disable iff (g_reset)
                   (dmem.dmem_req && !dmem.dmem_gnt) |=>
                   (dmem.dmem_req && $stable(dmem.dmem_wen) && $stable(dmem.dmem_strb) &&
                    $stable(dmem.dmem_wdata) && $stable(dmem.dmem_addr)));

endmodule

// File: tb/tb_frv_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_frv_dmem_responder
// Drives frv_dmem_responder with directed and random traffic. Accepted
// requests are turned into expected responses by a word-array memory model and
// queued; a negedge monitor checks grant/recv against the outstanding-count
// rule and compares every consumed response against the queue head.
// -----------------------------------------------------------------------------
module tb_frv_dmem_responder;

  localparam int MEM_WORDS = 1024;
  localparam int RSP_DEPTH = 2;

  logic g_clk    = 1'b0;
  logic g_reset  = 1'b1;
  logic gnt_hold = 1'b0;

  frv_dmem_responder_if dmem ();

  frv_dmem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .gnt_hold (gnt_hold),
    .dmem     (dmem)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    bit        err;
    bit [31:0] rdata;
    int        acc_cyc;
  } exp_t;

  int        n_tests   = 0;
  int        n_fail    = 0;
  int        cyc       = 0;
  int        n_grants  = 0;
  int        n_err_rsp = 0;
  int        grant_cyc[$];
  exp_t      sb[$];
  bit [31:0] model_mem [int unsigned];
  bit [31:0] last_rdata;
  bit        rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: a request's effect and response follow directly from the
  // address range and byte strobes.
  function automatic void model_accept(input bit wen, input bit [3:0] strb,
                                       input bit [31:0] wd, input bit [31:0] addr,
                                       input int c);
    int unsigned w = addr >> 2;
    bit [31:0]   word;
    exp_t        e;
    e.acc_cyc = c;
    e.err     = 1'b0;
    e.rdata   = '0;
    if (w >= MEM_WORDS) begin
      e.err = 1'b1;
    end else if (wen) begin
      word = model_mem.exists(w) ? model_mem[w] : 32'h0;
      for (int i = 0; i < 4; i++) if (strb[i]) word[8*i +: 8] = wd[8*i +: 8];
      model_mem[w] = word;
    end else begin
      e.rdata = model_mem.exists(w) ? model_mem[w] : 32'h0;
    end
    sb.push_back(e);
    n_grants++;
    grant_cyc.push_back(c);
  endfunction

  always @(posedge g_clk) cyc++;

  // Monitor: everything is sampled mid-cycle, after inputs have settled.
  always @(negedge g_clk) begin
    bit   exp_recv;
    bit   exp_gnt;
    bit   pop_m;
    int   occ_m;
    exp_t e;
    if (g_reset) begin
      check("gnt_in_reset", dmem.dmem_gnt, 1'b0);
      sb.delete();
    end else begin
      exp_recv = (sb.size() > 0) && (sb[0].acc_cyc < cyc);
      pop_m    = exp_recv && dmem.dmem_ack;
      occ_m    = sb.size() - (pop_m ? 1 : 0);
      exp_gnt  = dmem.dmem_req && !gnt_hold && (occ_m < RSP_DEPTH);
      check("recv", dmem.dmem_recv, exp_recv);
      check("gnt", dmem.dmem_gnt, exp_gnt);
      if (!exp_recv) begin
        check("idle_rdata", dmem.dmem_rdata, 32'h0);
        check("idle_error", dmem.dmem_error, 1'b0);
      end
      if (pop_m) begin
        e = sb.pop_front();
        check("rsp_rdata", dmem.dmem_rdata, e.rdata);
        check("rsp_error", dmem.dmem_error, e.err);
        last_rdata = dmem.dmem_rdata;
        if (dmem.dmem_error) n_err_rsp++;
      end
      if (dmem.dmem_req && dmem.dmem_gnt)
        model_accept(dmem.dmem_wen, dmem.dmem_strb, dmem.dmem_wdata, dmem.dmem_addr, cyc);
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Presents one request and holds it until granted (bounded wait).
  task automatic issue(input bit wen, input bit [3:0] strb, input bit [31:0] wd,
                       input bit [31:0] addr);
    int waited = 0;
    dmem.dmem_req   = 1'b1;
    dmem.dmem_wen   = wen;
    dmem.dmem_strb  = strb;
    dmem.dmem_wdata = wd;
    dmem.dmem_addr  = addr;
    forever begin
      @(negedge g_clk);
      if (dmem.dmem_gnt) break;
      waited++;
      if (waited > 500) begin
        check("grant_timeout", dmem.dmem_gnt, 1'b1);
        break;
      end
    end
    tick();
    dmem.dmem_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    dmem.dmem_ack = 1'b1;
    while (sb.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit [31:0] w0;
    bit [31:0] w6;
    int        g0;
    int        e0;

    dmem.dmem_req   = 1'b0;
    dmem.dmem_wen   = 1'b0;
    dmem.dmem_strb  = 4'h0;
    dmem.dmem_wdata = '0;
    dmem.dmem_addr  = '0;
    dmem.dmem_ack   = 1'b0;
    rand_done       = 1'b0;

    // Reset state; a request during reset is never granted.
    repeat (3) tick();
    check("rst_recv", dmem.dmem_recv, 1'b0);
    check("rst_error", dmem.dmem_error, 1'b0);
    check("rst_rdata", dmem.dmem_rdata, 32'h0);
    dmem.dmem_req = 1'b1;
    #1;
    check("rst_gnt", dmem.dmem_gnt, 1'b0);
    dmem.dmem_req = 1'b0;
    tick();
    g_reset = 1'b0;

    // Give words 0..15 known contents.
    dmem.dmem_ack = 1'b1;
    for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, $urandom, 32'(i * 4));
    drain();

    // Write then read.
    issue(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h10);
    issue(1'b0, 4'h0, 32'h0, 32'h10);
    drain();
    check("wr_rd_data", last_rdata, 32'hDEAD_BEEF);

    // Partial store into byte lane 1.
    issue(1'b1, 4'h2, 32'h0000_AB00, 32'h10);
    issue(1'b0, 4'h0, 32'h0, 32'h13);
    drain();
    check("partial_data", last_rdata, 32'hDEAD_ABEF);

    // Out of range: flagged, no write, no aliasing onto word 0.
    w0 = model_mem[0];
    e0 = n_err_rsp;
    issue(1'b1, 4'hF, 32'hFFFF_FFFF, 32'h1000);
    issue(1'b0, 4'h0, 32'h0, 32'h1000);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    drain();
    check("oor_err_count", n_err_rsp - e0, 2);
    check("oor_word0", last_rdata, w0);

    // Back-pressure with ack low for 5 cycles.
    dmem.dmem_ack = 1'b0;
    g0 = n_grants;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(1'b0, 4'h0, 32'h0, 32'((i + 4) * 4));
      end
      begin
        repeat (5) @(posedge g_clk);
        #1;
        check("bp_grants_ack_low", n_grants - g0, 2);
        dmem.dmem_ack = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        check("bp_grants_after_pops", n_grants - g0, 4);
      end
    join
    drain();

    // Throttle.
    gnt_hold = 1'b1;
    fork
      issue(1'b0, 4'h0, 32'h0, 32'h14);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge g_clk);
          check("hold_gnt", dmem.dmem_gnt, 1'b0);
        end
        @(posedge g_clk);
        #1;
        gnt_hold = 1'b0;
      end
    join
    drain();

    // Reset with two queued responses and a store presented during reset.
    dmem.dmem_ack = 1'b0;
    issue(1'b0, 4'h0, 32'h0, 32'h18);
    issue(1'b0, 4'h0, 32'h0, 32'h1C);
    tick();
    check("queued_recv", dmem.dmem_recv, 1'b1);
    g_reset         = 1'b1;
    dmem.dmem_req   = 1'b1;
    dmem.dmem_wen   = 1'b1;
    dmem.dmem_strb  = 4'hF;
    dmem.dmem_wdata = 32'h5A5A_5A5A;
    dmem.dmem_addr  = 32'h20;
    tick();
    g_reset       = 1'b0;
    dmem.dmem_req = 1'b0;
    check("post_rst_recv", dmem.dmem_recv, 1'b0);
    check("post_rst_rdata", dmem.dmem_rdata, 32'h0);
    w6 = model_mem[6];
    issue(1'b0, 4'h0, 32'h0, 32'h20);
    issue(1'b0, 4'h0, 32'h0, 32'h18);
    drain();
    check("post_rst_mem", last_rdata, w6);

    // Streaming store/load pairs to one word with ack held high.
    dmem.dmem_ack = 1'b1;
    grant_cyc.delete();
    g0 = n_grants;
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 4'hF, $urandom, 32'h24);
      issue(1'b0, 4'h0, 32'h0, 32'h24);
    end
    check("stream_grants", n_grants - g0, 16);
    check("stream_span", grant_cyc[$] - grant_cyc[0], 15);
    drain();

    // Random traffic with random ack and gnt_hold.
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          bit [31:0] addr;
          if ($urandom_range(0, 7) == 0)
            addr = 32'($urandom_range(MEM_WORDS, MEM_WORDS + 4000) * 4) | 32'($urandom_range(0, 3));
          else
            addr = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
          issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, addr);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          dmem.dmem_ack = 1'($urandom_range(0, 1));
          gnt_hold      = ($urandom_range(0, 3) == 0);
        end
        gnt_hold = 1'b0;
      end
    join
    drain();
    repeat (2) tick();
    check("final_outstanding", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
